// File: rtl/cp2_tx_queue.sv
// CP2 transmit queue: captures MEM-stage strobed words once, delivers them in order over valid/ready.
// Optional macro CP2_TXQ_BYPASS_EN: when empty, a new word is presented to CP2 in the same cycle.
module cp2_tx_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          cp2_tds_0,
  input  logic [31:0]   cp2_tdata_0,
  input  logic          cp2_q_clr,
  input  logic          ovf_clr,
  input  logic          cp2_tready,
  output logic          cp2_tvalid,
  output logic [31:0]   cp2_tdata,
  output logic          cp2_q_stall,
  output logic [AW:0]   cp2_q_count,
  output logic          cp2_q_ovf
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STALL_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic wr, rd, wr_acc, drop, empty, head_valid;
  logic bypass_act, bypass_take;

  // The MEM strobe stays high across a stall; only the unstalled cycle writes.
  assign wr         = cp2_tds_0 & ~stall;
  assign empty      = (count_q == '0);
  assign head_valid = ~empty;

`ifdef CP2_TXQ_BYPASS_EN
  assign bypass_act  = empty & wr;
  assign bypass_take = bypass_act & cp2_tready;
`else
  assign bypass_act  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Handshake: a word transfers on any cycle where cp2_tvalid and cp2_tready are both high;
  // cp2_tvalid/cp2_tdata hold until that transfer or a queue clear.
  assign cp2_tvalid = head_valid | bypass_act;
  assign cp2_tdata  = head_valid ? mem_q[rd_ptr_q] :
                      (bypass_act ? cp2_tdata_0 : 32'd0);

  assign rd     = head_valid & cp2_tready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign wr_acc = wr & ~bypass_take & ((count_q != FULL_CNT) | rd);
  assign drop   = wr & ~bypass_take & ~wr_acc;

  assign cp2_q_stall = (count_q >= STALL_CNT);
  assign cp2_q_count = count_q;
  assign cp2_q_ovf   = ovf_q;

  always_comb begin
    count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (cp2_q_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (reset && !cp2_q_clr && wr_acc) mem_q[wr_ptr_q] <= cp2_tdata_0;
  end

endmodule

// File: tb/tb_cp2_tx_queue.sv
// Self-checking bench for cp2_tx_queue: directed scenarios plus random traffic against a queue model.
module tb_cp2_tx_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset, stall, cp2_tds_0, cp2_q_clr, ovf_clr, cp2_tready;
  logic [31:0] cp2_tdata_0;
  logic        cp2_tvalid, cp2_q_stall, cp2_q_ovf;
  logic [31:0] cp2_tdata;
  logic [AW:0] cp2_q_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_ovf;

  always #5 clk = ~clk;

  cp2_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .cp2_tds_0(cp2_tds_0),
    .cp2_tdata_0(cp2_tdata_0), .cp2_q_clr(cp2_q_clr), .ovf_clr(ovf_clr),
    .cp2_tready(cp2_tready), .cp2_tvalid(cp2_tvalid), .cp2_tdata(cp2_tdata),
    .cp2_q_stall(cp2_q_stall), .cp2_q_count(cp2_q_count), .cp2_q_ovf(cp2_q_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs to the model, advance the model across the edge.
  task automatic cycle(input logic tds, input logic st, input logic [31:0] d,
                       input logic clr, input logic oc, input logic rdy, input logic rst_n);
    logic        w, byp, exp_valid, r;
    logic [31:0] exp_data;
    int          n;
    reset = rst_n; stall = st; cp2_tds_0 = tds; cp2_tdata_0 = d;
    cp2_q_clr = clr; ovf_clr = oc; cp2_tready = rdy;
    #1;
    n = exp_q.size();
    w = tds & ~st;
`ifdef CP2_TXQ_BYPASS_EN
    byp = (n == 0) && w;
`else
    byp = 1'b0;
`endif
    exp_valid = (n != 0) || byp;
    exp_data  = (n != 0) ? exp_q[0] : (byp ? d : 32'd0);
    check("count", 32'(cp2_q_count), 32'(n));
    check("tvalid", 32'(cp2_tvalid), 32'(exp_valid));
    check("tdata", cp2_tdata, exp_data);
    check("stall", 32'(cp2_q_stall), 32'(n >= DEPTH - 1));
    check("ovf", 32'(cp2_q_ovf), 32'(exp_ovf));
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (clr) begin
      exp_q.delete();
    end else begin
      r = exp_valid && rdy;
      if (oc) exp_ovf = 1'b0;
      if (!(byp && rdy)) begin
        if (r) void'(exp_q.pop_front());
        if (w) begin
          if (n < DEPTH || r) exp_q.push_back(d);
          else exp_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, rdy, 1'b1);
  endtask

  task automatic push(input logic [31:0] d, input logic rdy);
    cycle(1'b1, 1'b0, d, 1'b0, 1'b0, rdy, 1'b1);
  endtask

  initial begin
    logic tds, st, clr, oc, rdy, rst_n;
    reset = 1'b0; stall = 1'b0; cp2_tds_0 = 1'b0; cp2_tdata_0 = '0;
    cp2_q_clr = 1'b0; ovf_clr = 1'b0; cp2_tready = 1'b0;
    exp_ovf = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;

    // Test 1: reset mid-traffic, then a write visible one cycle later
    push(32'h0000_0011, 1'b0);
    push(32'h0000_0022, 1'b0);
    cycle(1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_count_after_reset", 32'(cp2_q_count), 32'd0);
    check("t1_tdata_after_reset", cp2_tdata, 32'd0);
    push(32'hA5A5_0001, 1'b0);
    check("t1_visible", cp2_tdata, 32'hA5A5_0001);
    idle(1'b1);

    // Test 2: strobe held through a stall queues exactly once
    repeat (3) cycle(1'b1, 1'b1, 32'h0000_00C2, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h0000_00C2, 1'b0);
    check("t2_count", 32'(cp2_q_count), 32'd1);
    idle(1'b1);

    // Test 3: fill to full, then overflow
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    check("t3_stall_at_3", 32'(cp2_q_stall), 32'd1);
    push(32'd4, 1'b0);
    check("t3_count_full", 32'(cp2_q_count), 32'd4);
    check("t3_no_ovf", 32'(cp2_q_ovf), 32'd0);
    push(32'd99, 1'b0);
    check("t3_ovf", 32'(cp2_q_ovf), 32'd1);
    check("t3_count_kept", 32'(cp2_q_count), 32'd4);

    // Test 4: write into full queue with simultaneous read
    push(32'd5, 1'b1);
    check("t4_count", 32'(cp2_q_count), 32'd4);
    check("t4_head", cp2_tdata, 32'd2);
    repeat (4) idle(1'b1);
    check("t4_drained", 32'(cp2_q_count), 32'd0);

    // Test 5: clear together with a write
    push(32'hB1, 1'b0);
    push(32'hB2, 1'b0);
    push(32'hB3, 1'b0);
    cycle(1'b1, 1'b0, 32'hB4, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_count", 32'(cp2_q_count), 32'd0);
    check("t5_tvalid", 32'(cp2_tvalid), 32'd0);
    check("t5_ovf_kept", 32'(cp2_q_ovf), 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t5_ovf_cleared", 32'(cp2_q_ovf), 32'd0);

    // Test 6: write to empty queue with CP2 ready
    push(32'hDEAD_BEEF, 1'b1);
`ifdef CP2_TXQ_BYPASS_EN
    check("t6_count_bypass", 32'(cp2_q_count), 32'd0);
`else
    check("t6_count_stored", 32'(cp2_q_count), 32'd1);
    idle(1'b1);
    check("t6_count_drained", 32'(cp2_q_count), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tds   = ($urandom_range(0, 99) < 60);
      st    = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 99) < 45);
      clr   = ($urandom_range(0, 59) == 0);
      oc    = clr ? 1'b0 : ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle(tds, st, $urandom, clr, oc, rdy, rst_n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
